// File: rtl/fetch_queue_if.sv
// Instruction-memory request/response bus between the fetch queue (master)
// and the instruction memory (slave).
interface fetch_queue_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_ready, imem_rvalid, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ready, imem_rvalid, imem_rdata
  );
endinterface

// File: rtl/fetch_queue.sv
// Prefetching instruction fetch stage: credit-limited in-order requests, a small
// {instr, addr} FIFO, redirect with stale-response dropping, and a stallable output register.
module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_sel,
  input  logic [XLEN-1:0] jmp_addr,
  input  logic            stall,
  fetch_queue_if.master   imem,
  output logic            o_valid,
  output logic [XLEN-1:0] o_instruction,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pc4
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] fifo_instr [DEPTH];
  logic [XLEN-1:0] fifo_addr  [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;

  logic [CW:0]     credit;
  logic            accept;
  logic            resp;
  logic            push;
  logic            pop;
  logic [XLEN-1:0] resp_addr;

  // Counting in-flight requests against free FIFO slots means a response always has room.
  assign credit         = {1'b0, count} + {1'b0, outstanding};
  assign imem.imem_req  = !rst && !pc_sel && (credit < DEPTH_W);
  assign imem.imem_addr = pc;

  assign accept = imem.imem_req && imem.imem_ready;
  assign resp   = imem.imem_rvalid;
  assign push   = resp && (drop_cnt == '0) && !pc_sel;
  assign pop    = !stall && !pc_sel && (count != '0);

  // With nothing left to drop, all in-flight requests are consecutive and end at pc-4,
  // so the oldest one (the one answering now) sits at pc - 4*outstanding.
  assign resp_addr = pc - (XLEN'(outstanding) << 2);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc            <= RESET_PC;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      outstanding   <= '0;
      drop_cnt      <= '0;
      o_valid       <= 1'b0;
      o_instruction <= '0;
      o_pc          <= '0;
      o_pc4         <= '0;
    end else begin
      outstanding <= outstanding + CW'(accept) - CW'(resp);

      if (pc_sel) begin
        pc       <= {jmp_addr[XLEN-1:2], 2'b00};
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
        drop_cnt <= outstanding - CW'(resp);
      end else begin
        if (accept) begin
          pc <= pc + XLEN'(4);
        end
        if (resp && (drop_cnt != '0)) begin
          drop_cnt <= drop_cnt - CW'(1);
        end
        if (push) begin
          fifo_instr[wr_ptr] <= imem.imem_rdata;
          fifo_addr[wr_ptr]  <= resp_addr;
          wr_ptr             <= wr_ptr + PW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
        count <= count + CW'(push) - CW'(pop);
      end

      // A redirect or an empty queue while not stalled emits an all-zero bubble.
      if (!stall) begin
        if (pop) begin
          o_valid       <= 1'b1;
          o_instruction <= fifo_instr[rd_ptr];
          o_pc          <= fifo_addr[rd_ptr];
          o_pc4         <= fifo_addr[rd_ptr] + XLEN'(4);
        end else begin
          o_valid       <= 1'b0;
          o_instruction <= '0;
          o_pc          <= '0;
          o_pc4         <= '0;
        end
      end
    end
  end
endmodule
